// File: rtl/can_reg_pkg.sv
// ----------------------------------------------------------------------------
// can_reg_pkg
//   Shared types and constants for the CAN register-bank write path.
//   - reg_arb_state_t : arbiter FSM states (IDLE waits for a request, COMMIT
//                       presents the single-cycle write/ack to the bank).
//   - reg_src_t       : which requester owns the current write.
//   - Default geometry of the bank and the default config-register lock mask
//     (registers that the host may only write while in reset mode).
// ----------------------------------------------------------------------------
package can_reg_pkg;

  localparam int          CAN_REG_ADDR_W     = 5;
  localparam int          CAN_REG_DATA_W     = 8;
  localparam int          CAN_REG_NUM_REGS   = 32;
  localparam int          CAN_REG_STREAK_MAX = 4;
  localparam logic [31:0] CAN_REG_LOCK_MASK  = 32'h0000_01F0;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } reg_arb_state_t;

  typedef enum logic {
    SRC_HOST = 1'b0,
    SRC_CORE = 1'b1
  } reg_src_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/can_reg_addr_decode.sv
// ----------------------------------------------------------------------------
// can_reg_addr_decode
//   Purely combinational address decoder for the register bank.
//   Ports:
//     addr      in   ADDR_W     target register address
//     we_onehot out  NUM_REGS   one-hot select, all zero when out of range
//     in_range  out  1          1 when addr < NUM_REGS
// ----------------------------------------------------------------------------
module can_reg_addr_decode
  import can_reg_pkg::*;
#(
  parameter int ADDR_W   = CAN_REG_ADDR_W,
  parameter int NUM_REGS = CAN_REG_NUM_REGS
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] we_onehot,
  output logic                in_range
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves it unassigned and infers a latch.
    we_onehot = '0;
    in_range  = (32'(addr) < 32'(NUM_REGS));
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(addr) == 32'(i)) we_onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/can_reg_wr_arbiter.sv
// ----------------------------------------------------------------------------
// can_reg_wr_arbiter
//   Serialises register-bank writes from the host bus and the CAN core,
//   decodes the winning address into a one-hot write enable and rejects
//   illegal writes (out-of-range address, or a host write to a lock-masked
//   config register while the controller is not in reset mode).
//
//   The write decision is taken at the IDLE->COMMIT edge from the values
//   presented in the IDLE cycle (address, data, source and reset_mode), and
//   is held in the output flops for the single COMMIT cycle. A change of
//   reset_mode during COMMIT therefore cannot affect the write in flight.
//
//   Ports:
//     clk, rst_sync_n        clock, synchronous active-low reset
//     reset_mode             controller reset-mode flag
//     host_req/addr/wdata    host write request (held until host_ack)
//     host_ack, host_err     1-cycle completion pulse, error qualifier
//     core_req/addr/wdata    core write request (held until core_ack)
//     core_ack, core_err     1-cycle completion pulse, error qualifier
//     reg_we, reg_wdata      one-hot write enable and data to the bank
//     rej_cnt, rej_clr       saturating reject counter and its clear
//     busy                   1 while a write is being committed
// ----------------------------------------------------------------------------
module can_reg_wr_arbiter
  import can_reg_pkg::*;
#(
  parameter int          ADDR_W     = CAN_REG_ADDR_W,
  parameter int          DATA_W     = CAN_REG_DATA_W,
  parameter int          NUM_REGS   = CAN_REG_NUM_REGS,
  parameter int          STREAK_MAX = CAN_REG_STREAK_MAX,
  parameter logic [31:0] LOCK_MASK  = CAN_REG_LOCK_MASK
) (
  input  logic                clk,
  input  logic                rst_sync_n,
  input  logic                reset_mode,
  input  logic                host_req,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic                host_ack,
  output logic                host_err,
  input  logic                core_req,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  output logic                core_ack,
  output logic                core_err,
  output logic [NUM_REGS-1:0] reg_we,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic [7:0]          rej_cnt,
  input  logic                rej_clr,
  output logic                busy
);

  localparam int STREAK_W = $clog2(STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STREAK_MAX);

  reg_arb_state_t      state_q,     state_d;
  logic [STREAK_W-1:0] streak_q,    streak_d;
  logic [7:0]          rej_cnt_q,   rej_cnt_d;
  logic [NUM_REGS-1:0] reg_we_q,    reg_we_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                host_ack_q,  host_ack_d;
  logic                host_err_q,  host_err_d;
  logic                core_ack_q,  core_ack_d;
  logic                core_err_q,  core_err_d;
  logic                busy_q,      busy_d;

  // Winner selection. The core has priority, except that once it has been
  // granted STREAK_MAX times in a row over a waiting host, the host wins.
  reg_src_t            win_src;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic [NUM_REGS-1:0] win_onehot;
  logic                win_in_range;
  logic                win_locked;
  logic                win_legal;
  logic                grant;
  logic                reject;

  always_comb begin
    win_src   = (host_req && (!core_req || streak_q == STREAK_TOP)) ? SRC_HOST
                                                                   : SRC_CORE;
    win_addr  = (win_src == SRC_HOST) ? host_addr  : core_addr;
    win_wdata = (win_src == SRC_HOST) ? host_wdata : core_wdata;
  end

  can_reg_addr_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_decode (
    .addr      (win_addr),
    .we_onehot (win_onehot),
    .in_range  (win_in_range)
  );

  // Core writes are never locked; the lock only gates host writes to config
  // registers while the controller is running (reset_mode=0).
  assign win_locked = (win_src == SRC_HOST) && LOCK_MASK[win_addr] && !reset_mode;
  assign win_legal  = win_in_range && !win_locked;

  // Requests are only sampled in IDLE, so a req held through COMMIT is not
  // granted a second time.
  assign grant = (state_q == IDLE) && (host_req || core_req);

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    reg_we_d    = '0;
    reg_wdata_d = reg_wdata_q;
    host_ack_d  = 1'b0;
    host_err_d  = 1'b0;
    core_ack_d  = 1'b0;
    core_err_d  = 1'b0;
    busy_d      = 1'b0;
    reject      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = COMMIT;
          busy_d  = 1'b1;
          if (win_legal) begin
            reg_we_d    = win_onehot;
            reg_wdata_d = win_wdata;
          end else begin
            reject = 1'b1;
          end

          if (win_src == SRC_HOST) begin
            host_ack_d = 1'b1;
            host_err_d = !win_legal;
            streak_d   = '0;
          end else begin
            core_ack_d = 1'b1;
            core_err_d = !win_legal;
            // Only consecutive core grants that make the host wait count.
            if (!host_req)                    streak_d = '0;
            else if (streak_q != STREAK_TOP)  streak_d = streak_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over a coincident reject.
    if (rej_clr)     rej_cnt_d = '0;
    else if (reject) rej_cnt_d = sat_inc8(rej_cnt_q);
    else             rej_cnt_d = rej_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_sync_n) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      rej_cnt_q   <= '0;
      reg_we_q    <= '0;
      reg_wdata_q <= '0;
      host_ack_q  <= 1'b0;
      host_err_q  <= 1'b0;
      core_ack_q  <= 1'b0;
      core_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every flop
      // samples the pre-edge value of its neighbours, independent of order.
      state_q     <= state_d;
      streak_q    <= streak_d;
      rej_cnt_q   <= rej_cnt_d;
      reg_we_q    <= reg_we_d;
      reg_wdata_q <= reg_wdata_d;
      host_ack_q  <= host_ack_d;
      host_err_q  <= host_err_d;
      core_ack_q  <= core_ack_d;
      core_err_q  <= core_err_d;
      busy_q      <= busy_d;
    end
  end

  assign host_ack  = host_ack_q;
  assign host_err  = host_err_q;
  assign core_ack  = core_ack_q;
  assign core_err  = core_err_q;
  assign reg_we    = reg_we_q;
  assign reg_wdata = reg_wdata_q;
  assign rej_cnt   = rej_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_can_reg_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_can_reg_wr_arbiter
//   Directed and randomised stimulus for can_reg_wr_arbiter with a bank of
//   24 registers (so addresses 24..31 are out of range). Expected results
//   come from a transaction-level model: who wins, whether the write is
//   legal, the grant streak and the saturating reject count.
// ----------------------------------------------------------------------------
module tb_can_reg_wr_arbiter;

  localparam int          NREGS = 24;
  localparam int          SMAX  = 4;
  localparam logic [31:0] LMASK = 32'h0000_01F0;

  logic        clk = 1'b0;
  logic        rst_sync_n;
  logic        reset_mode;
  logic        host_req;
  logic [4:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic        host_err;
  logic        core_req;
  logic [4:0]  core_addr;
  logic [7:0]  core_wdata;
  logic        core_ack;
  logic        core_err;
  logic [NREGS-1:0] reg_we;
  logic [7:0]  reg_wdata;
  logic [7:0]  rej_cnt;
  logic        rej_clr;
  logic        busy;

  can_reg_wr_arbiter #(
    .ADDR_W     (5),
    .DATA_W     (8),
    .NUM_REGS   (NREGS),
    .STREAK_MAX (SMAX),
    .LOCK_MASK  (LMASK)
  ) dut (
    .clk        (clk),
    .rst_sync_n (rst_sync_n),
    .reset_mode (reset_mode),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_err   (host_err),
    .core_req   (core_req),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_ack   (core_ack),
    .core_err   (core_err),
    .reg_we     (reg_we),
    .reg_wdata  (reg_wdata),
    .rej_cnt    (rej_cnt),
    .rej_clr    (rej_clr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  int          m_streak;
  int          m_cnt;
  logic [7:0]  m_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_streak = 0;
    m_cnt    = 0;
    m_wdata  = 8'h00;
  endtask

  // One request slot: drive in IDLE, check the COMMIT cycle against the
  // model, then check the following IDLE cycle. With hold=1 the requests
  // stay asserted throughout (back-to-back contention).
  task automatic do_txn(input string tag,
                        input logic h, input logic [4:0] ha, input logic [7:0] hd,
                        input logic c, input logic [4:0] ca, input logic [7:0] cd,
                        input logic rm, input logic clr, input logic hold,
                        output logic host_won);
    logic        any;
    logic [4:0]  a;
    logic        legal;
    logic [31:0] exp_we;

    host_req = h; host_addr = ha; host_wdata = hd;
    core_req = c; core_addr = ca; core_wdata = cd;
    reset_mode = rm; rej_clr = clr;

    any      = h | c;
    host_won = h && (!c || m_streak == SMAX);
    a        = host_won ? ha : ca;
    legal    = (int'(a) < NREGS) && !(host_won && LMASK[a] && !rm);
    exp_we   = (any && legal) ? (32'd1 << a) : 32'd0;
    if (any) begin
      if (host_won)  m_streak = 0;
      else if (h)    m_streak = (m_streak < SMAX) ? m_streak + 1 : SMAX;
      else           m_streak = 0;
      if (legal)     m_wdata  = host_won ? hd : cd;
    end
    if (clr)                m_cnt = 0;
    else if (any && !legal) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;

    tick();
    // Flip reset_mode during COMMIT: must not affect the write in flight.
    reset_mode = ~rm;
    rej_clr    = 1'b0;
    check({tag, ".host_ack"}, 32'(host_ack), 32'(any &&  host_won));
    check({tag, ".core_ack"}, 32'(core_ack), 32'(any && !host_won));
    check({tag, ".host_err"}, 32'(host_err), 32'(any &&  host_won && !legal));
    check({tag, ".core_err"}, 32'(core_err), 32'(any && !host_won && !legal));
    check({tag, ".reg_we"},   32'(reg_we),   exp_we);
    check({tag, ".wdata"},    32'(reg_wdata), 32'(m_wdata));
    check({tag, ".rej_cnt"},  32'(rej_cnt),  32'(m_cnt));
    check({tag, ".busy"},     32'(busy),     32'(any));
    if (!hold) begin
      host_req = 1'b0;
      core_req = 1'b0;
    end

    tick();
    check({tag, ".idle_we"},   32'(reg_we),   32'd0);
    check({tag, ".idle_ack"},  32'({host_ack, core_ack, host_err, core_err}), 32'd0);
    check({tag, ".idle_busy"}, 32'(busy),     32'd0);
    check({tag, ".idle_wd"},   32'(reg_wdata), 32'(m_wdata));
  endtask

  initial begin
    logic hw;
    logic h, c, rm, clr;

    rst_sync_n = 1'b0; reset_mode = 1'b1; rej_clr = 1'b0;
    host_req = 1'b0; host_addr = '0; host_wdata = '0;
    core_req = 1'b0; core_addr = '0; core_wdata = '0;
    model_reset();

    // Reset state.
    tick(); tick();
    check("rst.reg_we",  32'(reg_we),  32'd0);
    check("rst.wdata",   32'(reg_wdata), 32'd0);
    check("rst.acks",    32'({host_ack, core_ack, host_err, core_err}), 32'd0);
    check("rst.rej_cnt", 32'(rej_cnt), 32'd0);
    check("rst.busy",    32'(busy),    32'd0);
    rst_sync_n = 1'b1;
    tick();

    // Host-only write in reset mode to a locked register: accepted.
    do_txn("host4", 1, 5'd4, 8'hA5, 0, 5'd0, 8'h00, 1, 0, 0, hw);
    check("host4.we_lit", 32'(reg_we), 32'd0); // idle after commit
    // Lock: running mode, host to addr 6 is rejected, addr 1 accepted.
    do_txn("lock6", 1, 5'd6, 8'h3C, 0, 5'd0, 8'h00, 0, 0, 0, hw);
    check("lock6.cnt_lit", 32'(rej_cnt), 32'd1);
    do_txn("free1", 1, 5'd1, 8'h5A, 0, 5'd0, 8'h00, 0, 0, 0, hw);

    // Contention: both held continuously -> C,C,C,C,H repeating.
    for (int k = 0; k < 10; k++) begin
      do_txn("cont", 1, 5'd2, 8'h11, 1, 5'd3, 8'h22, 1, 0, 1, hw);
      check("cont.pattern", 32'(hw), 32'((k % 5) == 4));
    end
    host_req = 1'b0; core_req = 1'b0;

    // Range: core to addr 31 with 24 registers.
    do_txn("range31", 0, 5'd0, 8'h00, 1, 5'd31, 8'h77, 0, 0, 0, hw);
    check("range31.cnt_lit", 32'(rej_cnt), 32'd2);
    // Core to a lock-masked address while running: core is never locked.
    do_txn("core7", 0, 5'd0, 8'h00, 1, 5'd7, 8'h99, 0, 0, 0, hw);

    // Reset during COMMIT.
    host_req = 1'b1; host_addr = 5'd2; host_wdata = 8'hEE; reset_mode = 1'b1;
    tick();
    check("rstmid.commit_we", 32'(reg_we), 32'h4);
    rst_sync_n = 1'b0; host_req = 1'b0;
    tick();
    check("rstmid.reg_we",  32'(reg_we),  32'd0);
    check("rstmid.acks",    32'({host_ack, core_ack}), 32'd0);
    check("rstmid.busy",    32'(busy),    32'd0);
    check("rstmid.rej_cnt", 32'(rej_cnt), 32'd0);
    rst_sync_n = 1'b1;
    model_reset();
    tick();

    // Saturation: 300 rejects, then clear coincident with a reject.
    for (int k = 0; k < 300; k++)
      do_txn("sat", 0, 5'd0, 8'h00, 1, 5'd31, 8'h00, 0, 0, 0, hw);
    check("sat.cnt_lit", 32'(rej_cnt), 32'hFF);
    do_txn("satclr", 0, 5'd0, 8'h00, 1, 5'd31, 8'h00, 0, 1, 0, hw);
    check("satclr.cnt_lit", 32'(rej_cnt), 32'd0);

    // Randomised traffic against the model.
    for (int k = 0; k < 300; k++) begin
      h   = 1'($urandom_range(0, 3) != 0);
      c   = 1'($urandom_range(0, 3) != 0);
      rm  = 1'($urandom_range(0, 1));
      clr = 1'($urandom_range(0, 7) == 0);
      do_txn("rand", h, 5'($urandom_range(0, 31)), 8'($urandom),
                     c, 5'($urandom_range(0, 31)), 8'($urandom), rm, clr, 0, hw);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
